// File: rtl/pixel_stream_source.sv
// rtl/pixel_stream_source.sv - AXI-Stream RGB888 test-pattern frame generator with blanking and backpressure
module pixel_stream_source #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int H_BLANK  = 16,
    parameter int V_BLANK  = 64
) (
    input  logic        clk,
    input  logic        aresetn,
    input  logic [31:0] ctl_reg,
    output logic [23:0] m_tdata,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic        m_tuser,
    output logic        m_tlast,
    output logic        frame_done,
    output logic [15:0] frame_count
);

    typedef enum logic [1:0] {IDLE, ACTIVE, LINE_GAP, FRAME_GAP} state_t;

    localparam logic [9:0]  H_LAST  = 10'(H_ACTIVE - 1);
    localparam logic [9:0]  V_LAST  = 10'(V_ACTIVE - 1);
    localparam logic [15:0] HB_LAST = 16'(H_BLANK - 1);
    localparam logic [15:0] VB_LAST = 16'(V_BLANK - 1);
    localparam logic [9:0]  BAR_W   = 10'((H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1);

    state_t      state, state_nxt;
    logic [9:0]  hc, vc, nx, ny;
    logic [15:0] gap_cnt;
    logic [1:0]  pat;
    logic [23:0] color;
    logic        load, sof, eof_xfer, valid_nxt;
    logic        unused_ctl;

    wire en        = ctl_reg[0];
    wire xfer      = m_tvalid & m_tready;
    wire eol       = (hc == H_LAST);
    wire last_line = (vc == V_LAST);

    assign unused_ctl = ^ctl_reg[7:3];

    function automatic logic [23:0] pixel(input logic [1:0] p, input logic [23:0] c,
                                          input logic [9:0] x, input logic [9:0] y);
        logic [9:0] b, qx, qy;
        logic [23:0] px;
        b  = x / BAR_W;
        qx = x / 10'd10;
        qy = y / 10'd10;
        px = 24'h000000;
        case (p)
            2'd0: px = c;
            2'd1: px = {x[7:0], x[7:0], y[7:0]};
            2'd2: begin
                if (b > 10'd7) b = 10'd7;
                case (b[2:0])
                    3'd0: px = 24'hFFFFFF;
                    3'd1: px = 24'hFFFF00;
                    3'd2: px = 24'h00FFFF;
                    3'd3: px = 24'h00FF00;
                    3'd4: px = 24'hFF00FF;
                    3'd5: px = 24'hFF0000;
                    3'd6: px = 24'h0000FF;
                    default: px = 24'h000000;
                endcase
            end
            default: px = (qx[0] ^ qy[0]) ? 24'hFFFFFF : 24'h000000;
        endcase
        return px;
    endfunction

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (en) state_nxt = ACTIVE;
            ACTIVE: begin
                if (xfer && eol) begin
                    if (!last_line)        state_nxt = (H_BLANK > 0) ? LINE_GAP : ACTIVE;
                    else if (V_BLANK > 0)  state_nxt = FRAME_GAP;
                    else                   state_nxt = en ? ACTIVE : IDLE;
                end
            end
            LINE_GAP:  if (gap_cnt == HB_LAST) state_nxt = ACTIVE;
            FRAME_GAP: if (gap_cnt == VB_LAST) state_nxt = en ? ACTIVE : IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // nx/ny are the coordinates after this edge; load presents pixel(nx,ny), sof re-latches the pattern
    always_comb begin
        load     = 1'b0;
        sof      = 1'b0;
        eof_xfer = 1'b0;
        nx       = hc;
        ny       = vc;
        case (state)
            IDLE: begin
                if (en) begin
                    load = 1'b1;
                    sof  = 1'b1;
                    nx   = 10'd0;
                    ny   = 10'd0;
                end
            end
            ACTIVE: begin
                if (xfer) begin
                    if (!eol) begin
                        nx   = hc + 10'd1;
                        load = 1'b1;
                    end else if (!last_line) begin
                        nx   = 10'd0;
                        ny   = vc + 10'd1;
                        load = (H_BLANK == 0);
                    end else begin
                        nx       = 10'd0;
                        ny       = 10'd0;
                        eof_xfer = 1'b1;
                        load     = (V_BLANK == 0) && en;
                        sof      = (V_BLANK == 0) && en;
                    end
                end
            end
            LINE_GAP:  load = (gap_cnt == HB_LAST);
            FRAME_GAP: begin
                load = (gap_cnt == VB_LAST) && en;
                sof  = (gap_cnt == VB_LAST) && en;
            end
            default: ;
        endcase
        valid_nxt = load | (m_tvalid & ~xfer);
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            hc          <= 10'd0;
            vc          <= 10'd0;
            gap_cnt     <= 16'd0;
            pat         <= 2'd0;
            color       <= 24'd0;
            m_tdata     <= 24'd0;
            m_tvalid    <= 1'b0;
            m_tuser     <= 1'b0;
            m_tlast     <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= 16'd0;
        end else begin
            hc         <= nx;
            vc         <= ny;
            gap_cnt    <= (state_nxt == state) ? gap_cnt + 16'd1 : 16'd0;
            m_tvalid   <= valid_nxt;
            frame_done <= eof_xfer;
            if (eof_xfer) frame_count <= frame_count + 16'd1;
            if (sof) begin
                pat   <= ctl_reg[2:1];
                color <= ctl_reg[31:8];
            end
            if (load) begin
                m_tdata <= pixel(sof ? ctl_reg[2:1] : pat, sof ? ctl_reg[31:8] : color, nx, ny);
                m_tuser <= (nx == 10'd0) && (ny == 10'd0);
                m_tlast <= (nx == H_LAST);
            end
        end
    end

endmodule

// File: tb/tb_pixel_stream_source.sv
// tb/tb_pixel_stream_source.sv - self-checking bench for pixel_stream_source on a reduced 40x24 raster
module tb_pixel_stream_source;

    localparam int H  = 40;
    localparam int V  = 24;
    localparam int HB = 4;
    localparam int VB = 8;

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic [31:0] ctl_reg = 32'd0;
    logic        m_tready = 1'b0;
    logic [23:0] m_tdata;
    logic        m_tvalid, m_tuser, m_tlast, frame_done;
    logic [15:0] frame_count;

    pixel_stream_source #(.H_ACTIVE(H), .V_ACTIVE(V), .H_BLANK(HB), .V_BLANK(VB)) dut (
        .clk(clk), .aresetn(aresetn), .ctl_reg(ctl_reg),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .m_tuser(m_tuser), .m_tlast(m_tlast),
        .frame_done(frame_done), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    typedef struct { logic [23:0] d; logic u; logic l; } beat_t;
    typedef struct { int tid; int x; int y; logic [23:0] exp; } vec_t;

    beat_t       exp_q[$];
    vec_t        vecs [17];
    logic [23:0] cap [V][H];
    int          n_total = 0, n_pass = 0;
    int          beats = 0, tlasts = 0, fd_cnt = 0, gaps_seen = 0, idle = 0, cx = 0, cy = 0;
    bit          armed = 0, gap_chk = 0, prev_stall = 0;
    logic [31:0] prev_out = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [23:0] model(input int p, input logic [23:0] c, input int x, input int y);
        logic [23:0] bars [8];
        int b;
        bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        case (p)
            0: return c;
            1: return {x[7:0], x[7:0], y[7:0]};
            2: begin
                b = x * 8 / H;
                if (b > 7) b = 7;
                return bars[b];
            end
            default: return (((x / 10) + (y / 10)) % 2 == 1) ? 24'hFFFFFF : 24'h000000;
        endcase
    endfunction

    task automatic push_frame(input logic [31:0] ctl);
        beat_t e;
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++) begin
                e.d = model(int'(ctl[2:1]), ctl[31:8], x, y);
                e.u = (x == 0 && y == 0);
                e.l = (x == H - 1);
                exp_q.push_back(e);
            end
    endtask

    // Monitor: scoreboard pop on each transfer, stall stability, blanking length
    task automatic mon_step();
        beat_t e;
        if (!aresetn) begin
            armed      = 0;
            prev_stall = 0;
        end else begin
            if (prev_stall)
                chk("stall_hold", 32'({m_tvalid, m_tuser, m_tlast, m_tdata}), prev_out);
            if (m_tvalid) begin
                if (armed && gap_chk) begin
                    chk(m_tuser ? "frame_gap" : "line_gap", idle, m_tuser ? VB : HB);
                    gaps_seen++;
                end
                armed = 0;
                if (m_tready) begin
                    if (exp_q.size() == 0) chk("sb_underflow", exp_q.size(), 1);
                    else begin
                        e = exp_q.pop_front();
                        chk("beat", 32'({m_tuser, m_tlast, m_tdata}), 32'({e.u, e.l, e.d}));
                    end
                    if (m_tuser) begin cx = 0; cy = 0; end
                    if (cy < V && cx < H) cap[cy][cx] = m_tdata;
                    cx++;
                    if (cx == H) begin cx = 0; cy++; end
                    beats++;
                    if (m_tlast) begin tlasts++; armed = 1; idle = 0; end
                end
            end else idle++;
            if (frame_done) fd_cnt++;
            prev_stall = m_tvalid && !m_tready;
            prev_out   = 32'({m_tvalid, m_tuser, m_tlast, m_tdata});
        end
    endtask

    task automatic run_frame(input string tag, input logic [31:0] ctl, input logic [31:0] ctl_mid,
                             input int mid_beat, input bit rnd, input int exp_gaps);
        int b0, t0, f0, g0;
        logic [15:0] fc0;
        ctl_reg = ctl;
        push_frame(ctl);
        b0 = beats; t0 = tlasts; f0 = fd_cnt; g0 = gaps_seen; fc0 = frame_count;
        for (int c = 0; c < 20000 && frame_count == fc0; c++) begin
            @(posedge clk); #1;
            m_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (mid_beat >= 0 && beats - b0 >= mid_beat) ctl_reg = ctl_mid;
        end
        @(negedge clk); #1;
        chk({tag, " beats"}, beats - b0, H * V);
        chk({tag, " tlasts"}, tlasts - t0, V);
        chk({tag, " frame_done"}, fd_cnt - f0, 1);
        chk({tag, " frame_count"}, 32'(frame_count), 32'(fc0 + 16'd1));
        chk({tag, " sb_left"}, exp_q.size(), 0);
        if (exp_gaps >= 0) chk({tag, " gaps"}, gaps_seen - g0, exp_gaps);
    endtask

    task automatic apply_vecs(input int tid);
        for (int i = 0; i < 17; i++)
            if (vecs[i].tid == tid)
                chk($sformatf("vec t%0d (%0d,%0d)", tid, vecs[i].x, vecs[i].y),
                    32'(cap[vecs[i].y][vecs[i].x]), 32'(vecs[i].exp));
    endtask

    initial begin
        int vcount;
        logic [15:0] fc_hold;
        vecs[0]  = '{1, 0, 0, 24'hFFFFFF};  vecs[1]  = '{1, 5, 0, 24'hFFFF00};
        vecs[2]  = '{1, 10, 3, 24'h00FFFF}; vecs[3]  = '{1, 20, 7, 24'hFF00FF};
        vecs[4]  = '{1, 39, 0, 24'h000000}; vecs[5]  = '{1, 29, 23, 24'hFF0000};
        vecs[6]  = '{4, 0, 0, 24'hABCDEF};  vecs[7]  = '{4, 39, 23, 24'hABCDEF};
        vecs[8]  = '{5, 3, 5, 24'h030305};  vecs[9]  = '{5, 39, 23, 24'h272717};
        vecs[10] = '{5, 16, 9, 24'h101009}; vecs[11] = '{6, 0, 0, 24'h000000};
        vecs[12] = '{6, 10, 0, 24'hFFFFFF}; vecs[13] = '{6, 10, 10, 24'h000000};
        vecs[14] = '{6, 0, 10, 24'hFFFFFF}; vecs[15] = '{6, 25, 13, 24'hFFFFFF};
        vecs[16] = '{6, 9, 9, 24'h000000};

        fork
            forever begin @(negedge clk); mon_step(); end
        join_none

        repeat (3) @(negedge clk);
        #1;
        chk("rst tvalid", 32'(m_tvalid), 0);
        chk("rst tuser", 32'(m_tuser), 0);
        chk("rst tlast", 32'(m_tlast), 0);
        chk("rst tdata", 32'(m_tdata), 0);
        chk("rst frame_done", 32'(frame_done), 0);
        chk("rst frame_count", 32'(frame_count), 0);
        @(posedge clk); #1;
        aresetn = 1'b1;
        m_tready = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        chk("idle tvalid", 32'(m_tvalid), 0);

        gap_chk = 1;
        run_frame("bars", 32'h0000_0005, 32'h0000_0005, -1, 0, 23);
        apply_vecs(1);
        run_frame("bars_stall", 32'h0000_0005, 32'h0000_0005, -1, 1, 24);
        run_frame("solid_chg", 32'h1234_5601, 32'hABCD_EF01, 400, 0, 24);
        run_frame("solid_new", 32'hABCD_EF01, 32'hABCD_EF01, -1, 0, 24);
        apply_vecs(4);

        gap_chk = 0;
        run_frame("disable", 32'h0000_0003, 32'h0000_0002, 400, 0, -1);
        apply_vecs(5);
        vcount = 0;
        fc_hold = frame_count;
        repeat (3 * VB + H) begin
            @(negedge clk); #1;
            if (m_tvalid) vcount++;
        end
        chk("idle after disable tvalid", vcount, 0);
        chk("idle after disable count", 32'(frame_count), 32'(fc_hold));

        ctl_reg = 32'h0000_0007;
        push_frame(ctl_reg);
        for (int c = 0; c < 5000 && !(cy == 5 && cx >= 20); c++) begin
            @(posedge clk); #1;
        end
        chk("reached mid-frame", 32'(cy), 5);
        aresetn = 1'b0;
        #1;
        chk("async rst tvalid", 32'(m_tvalid), 0);
        chk("async rst tuser", 32'(m_tuser), 0);
        chk("async rst tdata", 32'(m_tdata), 0);
        chk("async rst frame_count", 32'(frame_count), 0);
        ctl_reg = 32'd0;
        exp_q.delete();
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        aresetn = 1'b1;
        gap_chk = 1;
        run_frame("checker", 32'h0000_0007, 32'h0000_0007, -1, 0, 23);
        apply_vecs(6);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
